// File: rtl/zap_mem_arbiter_if.sv
// Wishbone-style memory port shared by the fetch and data paths.
// master: arbiter drives cyc/stb/we/adr/dat/sel; slave: memory drives ack/err/dat.
interface zap_mem_arbiter_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_dat;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we,
    output o_wb_adr, o_wb_dat, o_wb_sel,
    input  i_wb_ack, i_wb_err, i_wb_dat
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we,
    input  o_wb_adr, o_wb_dat, o_wb_sel,
    output i_wb_ack, i_wb_err, i_wb_dat
  );
endinterface

// File: rtl/zap_mem_arbiter.sv
// Memory port arbiter: data has fixed priority, a starvation counter forces
// fetch grants; one bus transaction in flight. Ports: i_clk, i_reset,
// fetch side i_instr_*/o_instr_*, data side i_data_*/o_data_*, wb bus.
module zap_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  input  logic        i_instr_flush,
  output logic        o_instr_ack,
  output logic        o_instr_err,
  output logic [31:0] o_instr_data,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_sel,
  output logic        o_data_ack,
  output logic        o_data_err,
  output logic [31:0] o_data_rdata,
  zap_mem_arbiter_if.master wb
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TEN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INSTR,
    S_DATA,
    S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic          r_side, w_side;
  logic          r_cyc, w_cyc;
  logic          r_we, w_we;
  logic [31:0]   r_adr, w_adr;
  logic [31:0]   r_dat, w_dat;
  logic [3:0]    r_sel, w_sel;
  logic          r_iack, w_iack;
  logic          r_ierr, w_ierr;
  logic [31:0]   r_idata, w_idata;
  logic          r_dack, w_dack;
  logic          r_derr, w_derr;
  logic [31:0]   r_drdata, w_drdata;
  logic [SW-1:0] r_starve, w_starve;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          r_abandon, w_abandon;

  logic w_fetch_wait;
  logic w_grant_d;
  logic w_tout;
  logic w_bus_end;
  logic w_bus_err;
  logic w_drop_iack;

  assign w_fetch_wait = i_instr_req && !i_instr_flush;
  assign w_grant_d    = i_data_req &&
                        (!w_fetch_wait || (r_starve < SLIM));

  // Timeout only fires when the slave is silent this cycle.
  assign w_tout    = TEN && (r_tcnt == TLAST) &&
                     !(wb.i_wb_ack || wb.i_wb_err);
  assign w_bus_end = wb.i_wb_ack || wb.i_wb_err || w_tout;
  assign w_bus_err = wb.i_wb_err || w_tout;

  // A flush seen now or earlier in this fetch kills its ack.
  assign w_drop_iack = r_abandon || i_instr_flush;

  always_comb begin
    w_state   = r_state;
    w_side    = r_side;
    w_cyc     = r_cyc;
    w_we      = r_we;
    w_adr     = r_adr;
    w_dat     = r_dat;
    w_sel     = r_sel;
    w_iack    = 1'b0;
    w_ierr    = 1'b0;
    w_idata   = r_idata;
    w_dack    = 1'b0;
    w_derr    = 1'b0;
    w_drdata  = r_drdata;
    w_starve  = r_starve;
    w_tcnt    = r_tcnt;
    w_abandon = r_abandon;
    unique case (r_state)
      S_IDLE: begin
        w_abandon = 1'b0;
        if (w_grant_d) begin
          w_state = S_DATA;
          w_side  = 1'b0;
          w_cyc   = 1'b1;
          w_we    = i_data_wr;
          w_adr   = i_data_addr;
          w_dat   = i_data_wdata;
          w_sel   = i_data_sel;
          w_tcnt  = '0;
          if (!i_instr_req)
            w_starve = '0;
          else if (r_starve != SLIM)
            w_starve = r_starve + 1'b1;
        end else if (w_fetch_wait) begin
          w_state  = S_INSTR;
          w_side   = 1'b1;
          w_cyc    = 1'b1;
          w_we     = 1'b0;
          w_adr    = i_instr_addr & 32'hFFFF_FFFC;
          w_dat    = '0;
          w_sel    = 4'hF;
          w_tcnt   = '0;
          w_starve = '0;
        end else if (!i_instr_req) begin
          w_starve = '0;
        end
      end
      S_INSTR: begin
        w_tcnt = r_tcnt + 1'b1;
        if (i_instr_flush)
          w_abandon = 1'b1;
        if (w_bus_end) begin
          w_state = S_DONE;
          w_cyc   = 1'b0;
          if (!w_drop_iack) begin
            w_iack  = 1'b1;
            w_ierr  = w_bus_err;
            w_idata = wb.i_wb_dat;
          end
        end
      end
      S_DATA: begin
        w_tcnt = r_tcnt + 1'b1;
        if (w_bus_end) begin
          w_state  = S_DONE;
          w_cyc    = 1'b0;
          w_dack   = 1'b1;
          w_derr   = w_bus_err;
          w_drdata = wb.i_wb_dat;
        end
      end
      S_DONE: begin
        w_state   = S_IDLE;
        w_abandon = 1'b0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_side    <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_iack    <= 1'b0;
      r_ierr    <= 1'b0;
      r_idata   <= '0;
      r_dack    <= 1'b0;
      r_derr    <= 1'b0;
      r_drdata  <= '0;
      r_starve  <= '0;
      r_tcnt    <= '0;
      r_abandon <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_side    <= w_side;
      r_cyc     <= w_cyc;
      r_we      <= w_we;
      r_adr     <= w_adr;
      r_dat     <= w_dat;
      r_sel     <= w_sel;
      r_iack    <= w_iack;
      r_ierr    <= w_ierr;
      r_idata   <= w_idata;
      r_dack    <= w_dack;
      r_derr    <= w_derr;
      r_drdata  <= w_drdata;
      r_starve  <= w_starve;
      r_tcnt    <= w_tcnt;
      r_abandon <= w_abandon;
    end
  end

  assign o_instr_ack  = r_iack;
  assign o_instr_err  = r_ierr;
  assign o_instr_data = r_idata;
  assign o_data_ack   = r_dack;
  assign o_data_err   = r_derr;
  assign o_data_rdata = r_drdata;

  assign wb.o_wb_cyc = r_cyc;
  assign wb.o_wb_stb = r_cyc;
  assign wb.o_wb_we  = r_we;
  assign wb.o_wb_adr = r_adr;
  assign wb.o_wb_dat = r_dat;
  assign wb.o_wb_sel = r_sel;

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Bench for zap_mem_arbiter: transaction vector table plus hand sequences
// for reset, starvation order, flush abandon and mid-transaction reset.
module tb_zap_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush;
  logic [31:0] i_addr;
  logic        i_ack, i_err;
  logic [31:0] i_data;
  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;

  int checks = 0;
  int failures = 0;

  zap_mem_arbiter_if wb_bus();

  zap_mem_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_instr_req  (i_req),
    .i_instr_addr (i_addr),
    .i_instr_flush(i_flush),
    .o_instr_ack  (i_ack),
    .o_instr_err  (i_err),
    .o_instr_data (i_data),
    .i_data_req   (d_req),
    .i_data_wr    (d_wr),
    .i_data_addr  (d_addr),
    .i_data_wdata (d_wdata),
    .i_data_sel   (d_sel),
    .o_data_ack   (d_ack),
    .o_data_err   (d_err),
    .o_data_rdata (d_rdata),
    .wb           (wb_bus)
  );

  always #5 clk = ~clk;

  // Slave: acks in the slv_lat-th cycle of cyc (0 = never answers).
  int          slv_lat = 1;
  logic        slv_err = 1'b0;
  logic [31:0] slv_dat = '0;
  int          cyc_cnt = 0;
  logic        gq[$];

  initial begin
    wb_bus.i_wb_ack = 1'b0;
    wb_bus.i_wb_err = 1'b0;
    wb_bus.i_wb_dat = '0;
    forever begin
      @(negedge clk);
      if (wb_bus.o_wb_cyc) begin
        cyc_cnt++;
        if (cyc_cnt == 1)
          gq.push_back(wb_bus.o_wb_adr < 32'h1000);
        if (slv_lat != 0 && cyc_cnt == slv_lat) begin
          wb_bus.i_wb_ack = !slv_err;
          wb_bus.i_wb_err = slv_err;
          wb_bus.i_wb_dat = slv_dat;
        end else begin
          wb_bus.i_wb_ack = 1'b0;
          wb_bus.i_wb_err = 1'b0;
        end
      end else begin
        cyc_cnt = 0;
        wb_bus.i_wb_ack = 1'b0;
        wb_bus.i_wb_err = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          instr;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          lat;
    bit          serr;
    logic [31:0] sdat;
    int          exp_tick;
    bit          exp_err;
    bit          chk_dat;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vt[6];

  initial begin
    int got, ack_t, cyc_n, seen, other, ackv;
    logic        e_err;
    logic [31:0] e_dat;

    vt[0] = '{1, 0, 32'h100, 0, 4'hF, 1, 0, 32'hE1A00000,
              2, 0, 1, 32'h100, 4'hF};
    vt[1] = '{0, 0, 32'h2000, 0, 4'h3, 3, 0, 32'h12345678,
              4, 0, 1, 32'h2000, 4'h3};
    vt[2] = '{0, 1, 32'h2004, 32'hCAFEF00D, 4'hF, 0, 0, 0,
              9, 1, 0, 32'h2004, 4'hF};
    vt[3] = '{1, 0, 32'h10B, 0, 4'hF, 2, 1, 0,
              3, 1, 0, 32'h108, 4'hF};
    vt[4] = '{0, 0, 32'h2008, 0, 4'hC, 1, 0, 32'h0000A5A5,
              2, 0, 1, 32'h2008, 4'hC};
    vt[5] = '{1, 0, 32'h1FC, 0, 4'hF, 4, 0, 32'hDEADBEEF,
              5, 0, 1, 32'h1FC, 4'hF};

    // Reset with both requests pending.
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h100; i_flush = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h2000;
    d_wdata = '0; d_sel = 4'hF;
    slv_lat = 1;
    tick; tick;
    chk("rst_cyc", 32'(wb_bus.o_wb_cyc), 0);
    chk("rst_stb", 32'(wb_bus.o_wb_stb), 0);
    chk("rst_adr", wb_bus.o_wb_adr, 0);
    chk("rst_sel", 32'(wb_bus.o_wb_sel), 0);
    chk("rst_iack", 32'(i_ack), 0);
    chk("rst_dack", 32'(d_ack), 0);
    reset = 1'b0;
    tick;
    chk("post_rst_cyc", 32'(wb_bus.o_wb_cyc), 1);
    chk("post_rst_adr", wb_bus.o_wb_adr, 32'h2000);

    // Both requests held: starvation order D,D,D,D,I,...
    for (int t = 0; t < 60 && gq.size() < 10; t++) tick;
    i_req = 1'b0; d_req = 1'b0;
    chk("starve_cnt", 32'(gq.size() >= 10), 1);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      chk($sformatf("starve_order%0d", i), 32'(gq[i]),
          32'(i == 4 || i == 9));
    tick; tick; tick; tick;

    // Single transactions from the table.
    foreach (vt[k]) begin
      slv_lat = vt[k].lat;
      slv_err = vt[k].serr;
      slv_dat = vt[k].sdat;
      i_req   = vt[k].instr;
      i_addr  = vt[k].addr;
      d_req   = !vt[k].instr;
      d_wr    = vt[k].wr;
      d_addr  = vt[k].addr;
      d_wdata = vt[k].wdata;
      d_sel   = vt[k].sel;
      got = 0; ack_t = 0; cyc_n = 0; seen = 0; other = 0;
      e_err = 1'b0; e_dat = '0;
      for (int t = 1; t <= 20 && got == 0; t++) begin
        tick;
        if (wb_bus.o_wb_cyc) begin
          cyc_n++;
          if (seen == 0) begin
            seen = 1;
            chk($sformatf("v%0d_adr", k), wb_bus.o_wb_adr, vt[k].exp_adr);
            chk($sformatf("v%0d_sel", k), 32'(wb_bus.o_wb_sel),
                32'(vt[k].exp_sel));
            chk($sformatf("v%0d_we", k), 32'(wb_bus.o_wb_we),
                32'(vt[k].wr));
            if (vt[k].wr)
              chk($sformatf("v%0d_wdat", k), wb_bus.o_wb_dat, vt[k].wdata);
          end
        end
        ackv = vt[k].instr ? int'(i_ack) : int'(d_ack);
        if ((vt[k].instr ? d_ack : i_ack) == 1'b1) other = 1;
        if (ackv != 0) begin
          got = 1;
          ack_t = t;
          e_err = vt[k].instr ? i_err : d_err;
          e_dat = vt[k].instr ? i_data : d_rdata;
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      chk($sformatf("v%0d_ack_tick", k), ack_t, vt[k].exp_tick);
      chk($sformatf("v%0d_err", k), 32'(e_err), 32'(vt[k].exp_err));
      if (vt[k].chk_dat)
        chk($sformatf("v%0d_data", k), e_dat, vt[k].sdat);
      chk($sformatf("v%0d_cyc_len", k), cyc_n, vt[k].exp_tick - 1);
      chk($sformatf("v%0d_other_ack", k), other, 0);
      tick;
      chk($sformatf("v%0d_ack_pulse", k),
          32'(vt[k].instr ? i_ack : d_ack), 0);
    end

    // Flush during a fetch: bus completes, ack suppressed.
    slv_lat = 5; slv_err = 1'b0; slv_dat = 32'h11112222;
    i_req = 1'b1; i_addr = 32'h100;
    tick;
    cyc_n = int'(wb_bus.o_wb_cyc);
    i_flush = 1'b1;
    tick;
    chk("flush_cyc_held", 32'(wb_bus.o_wb_cyc), 1);
    cyc_n += int'(wb_bus.o_wb_cyc);
    i_flush = 1'b0; i_req = 1'b0;
    other = 0;
    for (int t = 0; t < 12; t++) begin
      tick;
      cyc_n += int'(wb_bus.o_wb_cyc);
      if (i_ack) other = 1;
    end
    chk("flush_cyc_len", cyc_n, 5);
    chk("flush_no_ack", other, 0);

    // Flush in IDLE blocks the fetch grant for that cycle.
    slv_lat = 1;
    i_req = 1'b1; i_flush = 1'b1;
    tick;
    chk("flush_idle_block", 32'(wb_bus.o_wb_cyc), 0);
    i_flush = 1'b0;
    tick;
    chk("fetch_after_flush", 32'(wb_bus.o_wb_cyc), 1);
    i_req = 1'b0;
    tick; tick; tick;

    // Reset in the middle of a silent data write.
    slv_lat = 0;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h2010;
    tick; tick; tick;
    chk("mid_cyc", 32'(wb_bus.o_wb_cyc), 1);
    reset = 1'b1; d_req = 1'b0;
    tick;
    chk("mid_rst_cyc", 32'(wb_bus.o_wb_cyc), 0);
    chk("mid_rst_dack", 32'(d_ack), 0);
    reset = 1'b0;
    tick;
    chk("mid_rst_idle", 32'(wb_bus.o_wb_cyc), 0);
    chk("mid_rst_noack", 32'(d_ack | i_ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
